// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine front-panel stage.
//   - controller status codes reported on ws/rs/ss
//   - panel interlock FSM state encoding
//   - default debounce / lock timing constants and counter width
//   - all_complete(): decode of "every stage reports COMPLETE"
package wm_pkg;

  typedef enum logic [1:0] {
    ST_OFF      = 2'b00,
    ST_ACTIVE   = 2'b01,
    ST_COMPLETE = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKING,
    RUNNING,
    UNLOCK_WAIT
  } panel_state_e;

  localparam int unsigned DEF_DB_CYCLES   = 4;
  localparam int unsigned DEF_LOCK_SETTLE = 3;
  localparam int unsigned DEF_UNLOCK_HOLD = 5;

  // Every timing parameter is legal in 1..15, so four bits cover all counters.
  localparam int CNT_W = 4;

  function automatic logic all_complete(input logic [1:0] ws,
                                        input logic [1:0] rs,
                                        input logic [1:0] ss);
    return (ws == ST_COMPLETE) && (rs == ST_COMPLETE) && (ss == ST_COMPLETE);
  endfunction

endpackage

// File: rtl/wm_debounce.sv
// Two-flop synchroniser followed by a level debouncer.
// Ports:
//   clk  in  : clock, rising edge
//   rst  in  : synchronous active-high reset
//   din  in  : raw asynchronous, possibly bouncy input
//   dout out : debounced level
//   rise out : one-cycle pulse when dout goes 0 -> 1
//   fall out : one-cycle pulse when dout goes 1 -> 0
module wm_debounce
  import wm_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes sync1->sync2 a
  // real two-stage shift instead of a single wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == dout) begin
        // Any agreeing sample restarts the qualification window.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This is the DB_CYCLES-th consecutive differing sample.
        dout <= sync2;
        rise <= sync2;
        fall <= ~sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/wm_panel_ctrl.sv
// Front-panel and door-interlock stage ahead of the wash-cycle controller.
// Debounces the buttons and door sensor, sequences the door lock and issues
// single-cycle start/stop pulses only while the interlock allows it.
// Ports:
//   clk         in  : clock, rising edge
//   rst         in  : synchronous active-high reset
//   start_btn   in  : raw start push button
//   stop_btn    in  : raw stop push button
//   door_closed in  : raw door sensor, 1 = closed
//   ws, rs, ss  in  : controller stage status (00 off, 01 active, 10 complete)
//   start       out : one-cycle start pulse to the controller
//   stop        out : one-cycle stop pulse to the controller
//   door_lock   out : lock solenoid drive, 1 = engaged
//   door_err    out : sticky door fault, cleared by reset or an accepted start
module wm_panel_ctrl
  import wm_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter int unsigned LOCK_SETTLE = DEF_LOCK_SETTLE,
  parameter int unsigned UNLOCK_HOLD = DEF_UNLOCK_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       door_closed,
  input  logic [1:0] ws,
  input  logic [1:0] rs,
  input  logic [1:0] ss,
  output logic       start,
  output logic       stop,
  output logic       door_lock,
  output logic       door_err
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_SETTLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(UNLOCK_HOLD - 1);

  logic start_req;
  logic stop_req;
  logic door_lvl;
  logic door_fall;
  logic start_lvl, start_fall;
  logic stop_lvl, stop_fall;
  logic door_rise;
  logic done;

  wm_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk  (clk),
    .rst  (rst),
    .din  (start_btn),
    .dout (start_lvl),
    .rise (start_req),
    .fall (start_fall)
  );

  wm_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
    .clk  (clk),
    .rst  (rst),
    .din  (stop_btn),
    .dout (stop_lvl),
    .rise (stop_req),
    .fall (stop_fall)
  );

  wm_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_door (
    .clk  (clk),
    .rst  (rst),
    .din  (door_closed),
    .dout (door_lvl),
    .rise (door_rise),
    .fall (door_fall)
  );

  // Button levels and the unused edges are not needed by the interlock.
  logic unused_edges;
  assign unused_edges = &{1'b0, start_lvl, start_fall, stop_lvl, stop_fall, door_rise};

  assign done = all_complete(ws, rs, ss);

  panel_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_d, stop_d, lock_d, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNLOCKED;
      cnt_q     <= '0;
      start     <= 1'b0;
      stop      <= 1'b0;
      door_lock <= 1'b0;
      door_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start     <= start_d;
      stop      <= stop_d;
      door_lock <= lock_d;
      door_err  <= err_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    err_d   = door_err;

    unique case (state_q)
      UNLOCKED: begin
        // A simultaneous stop press swallows the start request.
        if (start_req && !stop_req) begin
          if (door_lvl) begin
            state_d = LOCKING;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOCKING: begin
        if (stop_req) begin
          state_d = UNLOCKED;
        end else if (!door_lvl) begin
          state_d = UNLOCKED;
          err_d   = 1'b1;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = RUNNING;
          start_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUNNING: begin
        if (stop_req) begin
          state_d = UNLOCK_WAIT;
          stop_d  = 1'b1;
          cnt_d   = '0;
        end else if (door_fall) begin
          state_d = UNLOCK_WAIT;
          stop_d  = 1'b1;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else if (done) begin
          // The controller finished on its own; no pulse needed.
          state_d = UNLOCK_WAIT;
          cnt_d   = '0;
        end
      end

      UNLOCK_WAIT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = UNLOCKED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = UNLOCKED;
      end
    endcase

    // The lock output follows the next state so it changes on the same edge
    // as the state register.
    lock_d = (state_d != UNLOCKED);
  end

endmodule

// File: doc/wm_panel_ctrl.md
# wm_panel_ctrl

Front-panel and door-interlock stage that sits directly upstream of the washing-machine cycle controller. It synchronises and debounces the raw start/stop push buttons and the door sensor, and drives the door lock. It issues single-cycle `start`/`stop` pulses to the controller only when the interlock permits. It watches the controller's `ws`/`rs`/`ss` status codes to learn when a cycle has finished and the door may be released.

## Interface
- `DB_CYCLES`, 4: consecutive stable samples required to accept a level change; legal 1–15.
- `LOCK_SETTLE`, 3: cycles the lock is held before `start` is issued; legal 1–15.
- `UNLOCK_HOLD`, 5: cycles the lock is held after the run ends; legal 1–15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start_btn` in 1: raw start button, asynchronous, bouncy.
- `stop_btn` in 1: raw stop button, asynchronous, bouncy.
- `door_closed` in 1: raw door sensor; 1 = closed.
- `ws`, `rs`, `ss` in 2 each: controller status; 00 = off, 01 = active, 10 = complete.
- `start` out 1: one-cycle pulse to the controller.
- `stop` out 1: one-cycle pulse to the controller.
- `door_lock` out 1: 1 = lock solenoid engaged.
- `door_err` out 1: sticky fault flag.

## Operation
- **Reset values.** All outputs are 0. Synchroniser and debounced levels are 0. Counters are 0. FSM is in UNLOCKED.
- **Synchroniser.** Each raw input passes through two flops.
- **Debounce, per input.**
  - The counter increments while the synchronised level differs from the debounced level.
  - Any agreeing sample clears the counter.
  - On the DB_CYCLES-th differing sample, the debounced level flips and the counter clears.
- **Request generation.**
  - `start_req` and `stop_req` are the rising edges of the debounced buttons.
  - `door_fall` is the falling edge of the debounced door level.
- **Status decode.** `done` = (`ws`==10 && `rs`==10 && `ss`==10).
- **Arbitration.** `stop_req` has priority over `start_req` in every state.
- **FSM states and transitions.**
  - **UNLOCKED** (`door_lock`=0):
    - `stop_req`: ignored.
    - `start_req` with door closed: go to LOCKING and clear `door_err`.
    - `start_req` with door open: set `door_err` and stay.
  - **LOCKING** (`door_lock`=1), counts LOCK_SETTLE cycles:
    - `stop_req` or door open: go to UNLOCKED with no pulses; door open also sets `door_err`.
    - Count reached: pulse `start` and go to RUNNING.
  - **RUNNING** (`door_lock`=1):
    - `stop_req`: pulse `stop` and go to UNLOCK_WAIT.
    - `door_fall`: pulse `stop`, set `door_err`, and go to UNLOCK_WAIT.
    - `done`: go to UNLOCK_WAIT with no pulse.
    - `start_req`: ignored.
  - **UNLOCK_WAIT** (`door_lock`=1):
    - Counts UNLOCK_HOLD cycles, then goes to UNLOCKED.
    - `start_req` and `stop_req` are ignored.
- **Output timing.** `start`, `stop` and `door_lock` are registered. `start` and `stop` are never high together and never high for more than one cycle.
- **`door_err`.** Cleared only by `rst` or by an accepted start from UNLOCKED.
- **Reset mid-operation.** Reset in any state returns everything to reset values on the next edge. No `stop` pulse is emitted.

## Timing
Edge E is the first edge at which a raw input is sampled at its new clean level.
- **Start path, clean press, door closed.**
  - `door_lock` rises at edge E+2+DB_CYCLES.
  - `start` is high for the one cycle following edge E+2+DB_CYCLES+LOCK_SETTLE.
- **Stop path, from RUNNING.**
  - `stop` is high for the cycle following edge E+2+DB_CYCLES.
  - `door_lock` falls UNLOCK_HOLD edges later.
- **`done` path.** `done` is sampled in RUNNING; `door_lock` falls UNLOCK_HOLD+1 edges after the first cycle in which `done` is high.
- **Rejected bounces.** A bounce shorter than DB_CYCLES samples produces no request and no output change.

## Structure
- **Shared package `wm_pkg`:**
  - status codes: OFF=00, ACTIVE=01, COMPLETE=10;
  - this block's FSM state enum (UNLOCKED, LOCKING, RUNNING, UNLOCK_WAIT);
  - default timing constants.
- **Sub-module `wm_debounce`:**
  - ports: `clk`, `rst`, `din`, `dout`, `rise`, `fall`;
  - contents: 2-flop synchroniser plus debounce counter;
  - instantiated three times (`start_btn`, `stop_btn`, `door_closed`).

## Test plan
All scenarios use defaults DB_CYCLES=4, LOCK_SETTLE=3, UNLOCK_HOLD=5.
1. Door closed and stable, clean `start_btn` press at edge E -> `door_lock`=1 at E+6; one-cycle `start` after E+9; `stop` stays 0.
2. `start_btn` bounces with 3-cycle pulses, then holds -> exactly one `start` pulse, timed from the first edge of the final stable hold.
3. Door open, `start_btn` pressed -> `door_err`=1, `door_lock`=0, no `start`. Close the door and press again -> `door_err` clears, run proceeds as in scenario 1.
4. RUNNING, then `stop_btn` and `start_btn` pressed on the same edge -> one `stop` pulse, no `start`; `door_lock` falls 5 edges later.
5. RUNNING, then door opens -> `stop` pulse and `door_err`=1. Separately: RUNNING with `ws`=`rs`=`ss`=10 -> no pulses; `door_lock` falls 6 edges after `done` first appears.
6. `rst` asserted during LOCKING and during RUNNING -> all outputs 0 at the next edge, no `stop` pulse, FSM in UNLOCKED.
